rgb_sequencer: RTL and testbench
================================

RGB_SEQUENCER -- requirements
Module: rgb_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1000: clock cycles per tick; legal range is 2 or more.
REQ-002 SHALL have parameter STEP_TICKS, default 250: ticks per brightness step; legal range is 1 or more.
REQ-003 SHALL use one clock, and reset is synchronous and active-low.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 run  input  1  level; 1 = sequence running or paused, 0 = off.
REQ-007 pause  input  1  single-cycle pulse; toggles between RUN and PAUSED.
REQ-008 step  input  1  single-cycle pulse; advances one brightness step while PAUSED.
REQ-009 tick  output  1  one-cycle strobe, used as clock_enable by the downstream PWM controllers.
REQ-010 sw_r, sw_g, sw_b  output  2 each  duty-level codes for the three PWM controllers: 00=0%, 01=12.5%, 10=25%, 11=50%.
REQ-011 phase  output  3  current colour phase, range 0..5.

Function
REQ-012 Prescaler: counts 0..PRESCALE-1 and wraps to 0; tick=1 exactly in the cycle the count equals PRESCALE-1.
REQ-013 The prescaler SHALL run in every FSM state; it stops only during reset.
REQ-014 FSM states: OFF, RUN, PAUSED.
REQ-015 OFF: phase, level and step counter held at 0; all sw_* = 00.
REQ-016 OFF->RUN on the first cycle with run=1.
REQ-017 RUN->PAUSED on pause=1.
REQ-018 PAUSED->RUN on pause=1.
REQ-019 Any state->OFF on run=0; run=0 has priority over pause and step in the same cycle.
REQ-020 Leaving OFF, the sequence SHALL always start at phase 0, level 0.
REQ-021 RUN: the step counter (0..STEP_TICKS-1) increments on each tick; on a tick with count=STEP_TICKS-1 it clears and the sequence advances.
REQ-022 Advance rule: level 0..3 increments; at level 3 it clears to 0 and phase increments; phase wraps 5->0.
REQ-023 PAUSED: the step counter, level and phase hold; tick keeps running.
REQ-024 PAUSED with step=1 and pause=0: advance once per REQ-022 and clear the step counter.
REQ-025 PAUSED with step=1 and pause=1 together: the transition to RUN wins and step is ignored.
REQ-026 step is ignored in RUN and in OFF.
REQ-027 Decode, with L=level:
- phase 0: R=3, G=L, B=0
- phase 1: R=3-L, G=3, B=0
- phase 2: R=0, G=3, B=L
- phase 3: R=0, G=3-L, B=3
- phase 4: R=L, G=0, B=3
- phase 5: R=3, G=0, B=3-L
REQ-028 sw_* and phase SHALL be a decode of registered state only, with no input-to-output combinational path.
REQ-029 sw_* SHALL change in the clock cycle after the edge that advances the sequence.
REQ-030 All counters SHALL be sized with $clog2 of their range; no counter may exceed its terminal value.

Reset
REQ-031 With reset_n=0 at a rising edge: state=OFF, prescaler=0, step counter=0, level=0, phase=0.
REQ-032 Following REQ-031, tick=0 and sw_r, sw_g, sw_b = 00.
REQ-033 Reset SHALL take effect mid-operation in any state, with no residual tick.
REQ-034 The first tick after release SHALL occur PRESCALE cycles after the first edge sampled with reset_n=1.

Structure
REQ-035 Package rgb_pkg SHALL hold:
- the state enum (OFF, RUN, PAUSED)
- NUM_PHASES=6
- LVL_MAX=3
- the 2-bit duty-code typedef
REQ-036 Sub-module tick_prescaler SHALL contain the PRESCALE counter and the tick output; the FSM, counters and decode stay in rgb_sequencer.

Verification (PRESCALE=4, STEP_TICKS=2)
REQ-037 Reset: hold reset_n=0 for 3 cycles with run=1 -> tick=0, sw_r=sw_g=sw_b=00, phase=0 throughout.
REQ-038 Tick cadence: after release with run=0 -> tick high on cycles 4, 8, 12, ..., each one cycle wide; sw_* stay 00.
REQ-039 Sequence run: run=1 -> sw_g steps 00->01->10->11 every 8 clocks; phase becomes 1 after 32 clocks; after 192 clocks the outputs return to R=11, G=00, B=00 with phase=0.
REQ-040 Pause and step:
- pause in phase 2, level 1 -> outputs frozen for 100 clocks
- one step pulse -> level 2 (B=10) on the next cycle
- pause and step together -> RUN, level unchanged
REQ-041 Off and restart: run=0 in phase 4 -> sw_*=00 and phase=0 on the next cycle; run=1 again -> restarts at R=11, G=00, B=00.
REQ-042 Reset mid-operation: reset_n=0 for 1 cycle while PAUSED in phase 3 -> OFF state and all outputs 0; after release, tick period restarts at 4.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB colour-wheel sequencer.
//   state_e    : sequencer FSM states
//   duty_t     : 2-bit duty code (00=0%, 01=12.5%, 10=25%, 11=50%)
//   NUM_PHASES : colour phases per revolution (0..NUM_PHASES-1)
//   LVL_MAX    : top brightness level within a phase
package rgb_pkg;

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2
  } state_e;

  typedef logic [1:0] duty_t;

  localparam int unsigned NUM_PHASES = 6;
  localparam int unsigned LVL_MAX    = 3;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every PRESCALE clocks.
// Ports:
//   i_clock   : system clock
//   i_reset_n : synchronous active-low reset (clears the count)
//   o_tick    : high for the single cycle in which the count is PRESCALE-1
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic i_clock,
  input  logic i_reset_n,
  output logic o_tick
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (r_count == CntMax) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  // Decoded from the register so reset leaves no residual tick.
  assign o_tick = (r_count == CntMax);

endmodule

// File: rtl/rgb_sequencer.sv
// RGB colour-wheel sequencer. Walks six colour phases, each with four
// brightness levels, and emits duty codes for three PWM controllers.
// Ports:
//   clock, reset_n    : clock and synchronous active-low reset
//   run               : level; 1 = running or paused, 0 = off
//   pause             : pulse; toggles RUN <-> PAUSED
//   step              : pulse; single advance while PAUSED
//   tick              : prescaler strobe, also the PWM clock enable
//   sw_r, sw_g, sw_b  : duty codes, decoded from registered state only
//   phase             : current colour phase 0..5
module rgb_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned STEP_TICKS = 250
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic       pause,
  input  logic       step,
  output logic       tick,
  output logic [1:0] sw_r,
  output logic [1:0] sw_g,
  output logic [1:0] sw_b,
  output logic [2:0] phase
);

  localparam int unsigned StepW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [StepW-1:0] StepMax  = StepW'(STEP_TICKS - 1);
  localparam logic [1:0]       LvlMax   = 2'(LVL_MAX);
  localparam logic [2:0]       PhaseMax = 3'(NUM_PHASES - 1);

  state_e           r_state, w_state;
  logic [StepW-1:0] r_step_cnt, w_step_cnt;
  logic [1:0]       r_level, w_level;
  logic [2:0]       r_phase, w_phase;
  logic             w_advance;
  logic             w_tick;
  duty_t            w_r, w_g, w_b;
  logic [1:0]       w_inv;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= StOff;
      r_step_cnt <= '0;
      r_level    <= '0;
      r_phase    <= '0;
    end else begin
      r_state    <= w_state;
      r_step_cnt <= w_step_cnt;
      r_level    <= w_level;
      r_phase    <= w_phase;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_step_cnt = r_step_cnt;
    w_level    = r_level;
    w_phase    = r_phase;
    w_advance  = 1'b0;

    // run=0 overrides everything and parks the sequence at phase 0, level 0.
    if (!run) begin
      w_state    = StOff;
      w_step_cnt = '0;
      w_level    = '0;
      w_phase    = '0;
    end else begin
      unique case (r_state)
        StOff: begin
          w_state    = StRun;
          w_step_cnt = '0;
          w_level    = '0;
          w_phase    = '0;
        end
        StRun: begin
          if (pause) w_state = StPaused;
          if (w_tick) begin
            if (r_step_cnt == StepMax) begin
              w_step_cnt = '0;
              w_advance  = 1'b1;
            end else begin
              w_step_cnt = r_step_cnt + 1'b1;
            end
          end
        end
        StPaused: begin
          // Resuming takes precedence over a coincident step.
          if (pause) begin
            w_state = StRun;
          end else if (step) begin
            w_step_cnt = '0;
            w_advance  = 1'b1;
          end
        end
        default: w_state = StOff;
      endcase
    end

    if (w_advance) begin
      if (r_level == LvlMax) begin
        w_level = '0;
        w_phase = (r_phase == PhaseMax) ? 3'd0 : r_phase + 3'd1;
      end else begin
        w_level = r_level + 2'd1;
      end
    end
  end

  // Colour wheel: one channel ramps up or down per phase while the others sit at 0 or full.
  always_comb begin
    w_r   = 2'b00;
    w_g   = 2'b00;
    w_b   = 2'b00;
    w_inv = LvlMax - r_level;
    if (r_state != StOff) begin
      unique case (r_phase)
        3'd0: begin w_r = LvlMax; w_g = r_level; end
        3'd1: begin w_r = w_inv;  w_g = LvlMax;  end
        3'd2: begin w_g = LvlMax; w_b = r_level; end
        3'd3: begin w_g = w_inv;  w_b = LvlMax;  end
        3'd4: begin w_r = r_level; w_b = LvlMax; end
        3'd5: begin w_r = LvlMax; w_b = w_inv;   end
        default: begin
          w_r = 2'b00;
          w_g = 2'b00;
          w_b = 2'b00;
        end
      endcase
    end
  end

  assign tick  = w_tick;
  assign sw_r  = w_r;
  assign sw_g  = w_g;
  assign sw_b  = w_b;
  assign phase = r_phase;

endmodule

// File: tb/tb_rgb_sequencer.sv
module tb_rgb_sequencer;

  logic       clock = 1'b0;
  logic       reset_n, run, pause, step;
  logic       tick;
  logic [1:0] sw_r, sw_g, sw_b;
  logic [2:0] phase;

  int n_pass  = 0;
  int n_total = 0;
  int e       = 0;  // rising edges since the last reset release

  // Sequence checkpoints: edge number and expected {sw_r, sw_g, sw_b, phase}.
  int         ce [16] = '{1, 7, 8, 15, 16, 24, 31, 32, 40, 64, 96, 128, 160, 176, 191, 192};
  logic [8:0] cv [16] = '{
    9'b11_00_00_000, 9'b11_00_00_000, 9'b11_01_00_000, 9'b11_01_00_000,
    9'b11_10_00_000, 9'b11_11_00_000, 9'b11_11_00_000, 9'b11_11_00_001,
    9'b10_11_00_001, 9'b00_11_00_010, 9'b00_11_11_011, 9'b00_00_11_100,
    9'b11_00_11_101, 9'b11_00_01_101, 9'b11_00_00_101, 9'b11_00_00_000
  };

  always #5 clock = ~clock;

  rgb_sequencer #(
    .PRESCALE   (4),
    .STEP_TICKS (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (run),
    .pause   (pause),
    .step    (step),
    .tick    (tick),
    .sw_r    (sw_r),
    .sw_g    (sw_g),
    .sw_b    (sw_b),
    .phase   (phase)
  );

  task automatic clk_cycle();
    @(posedge clock);
    #1;
    e++;
  endtask

  task automatic start_seq();
    reset_n = 1'b0;
    run     = 1'b0;
    pause   = 1'b0;
    step    = 1'b0;
    clk_cycle();
    reset_n = 1'b1;
    run     = 1'b1;
    e       = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run     = 1'b1;
    pause   = 1'b0;
    step    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      n_total++;
      if (tick !== 1'b0) $display("FAIL reset_tick cyc=%0d got %b want 0", i, tick);
      else n_pass++;
      n_total++;
      if ({sw_r, sw_g, sw_b, phase} !== 9'b0)
        $display("FAIL reset_outs cyc=%0d got %b want %b", i, {sw_r, sw_g, sw_b, phase}, 9'b0);
      else n_pass++;
    end
  endtask

  task automatic test_tick_cadence();
    logic [12:1] pat;
    pat     = 12'b0100_0100_0100;
    run     = 1'b0;
    reset_n = 1'b1;
    e       = 0;
    for (int k = 1; k <= 12; k++) begin
      clk_cycle();
      n_total++;
      if (tick !== pat[k]) $display("FAIL cadence_tick e=%0d got %b want %b", e, tick, pat[k]);
      else n_pass++;
      n_total++;
      if ({sw_r, sw_g, sw_b, phase} !== 9'b0)
        $display("FAIL cadence_outs e=%0d got %b want %b", e, {sw_r, sw_g, sw_b, phase}, 9'b0);
      else n_pass++;
    end
  endtask

  task automatic test_sequence();
    int idx;
    idx = 0;
    start_seq();
    for (int k = 1; k <= 192; k++) begin
      clk_cycle();
      if (idx < 16 && e == ce[idx]) begin
        n_total++;
        if ({sw_r, sw_g, sw_b, phase} !== cv[idx])
          $display("FAIL seq e=%0d got %b want %b", e, {sw_r, sw_g, sw_b, phase}, cv[idx]);
        else n_pass++;
        idx++;
      end
    end
  endtask

  task automatic test_pause_step();
    start_seq();
    while (e < 72) clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_01_010)
      $display("FAIL pause_pre got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_11_01_010);
    else n_pass++;
    pause = 1'b1;
    clk_cycle();
    pause = 1'b0;
    for (int k = 0; k < 100; k++) begin
      clk_cycle();
      n_total++;
      if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_01_010)
        $display("FAIL pause_frozen e=%0d got %b want %b", e, {sw_r, sw_g, sw_b, phase},
                 9'b00_11_01_010);
      else n_pass++;
      if (e == 75) begin
        n_total++;
        if (tick !== 1'b1) $display("FAIL pause_tick e=%0d got %b want 1", e, tick);
        else n_pass++;
      end
    end
    step = 1'b1;
    clk_cycle();
    step = 1'b0;
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_10_010)
      $display("FAIL step_adv got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_11_10_010);
    else n_pass++;
    while (e < 180) clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_10_010)
      $display("FAIL step_hold got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_11_10_010);
    else n_pass++;
    pause = 1'b1;
    step  = 1'b1;
    clk_cycle();
    pause = 1'b0;
    step  = 1'b0;
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_10_010)
      $display("FAIL pause_step_both got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_11_10_010);
    else n_pass++;
    while (e < 187) clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_10_010)
      $display("FAIL resume_pre got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_11_10_010);
    else n_pass++;
    clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_11_010)
      $display("FAIL resume_adv got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_11_11_010);
    else n_pass++;
    step = 1'b1;
    clk_cycle();
    step = 1'b0;
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_11_010)
      $display("FAIL step_in_run got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_11_11_010);
    else n_pass++;
    while (e < 196) clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_11_011)
      $display("FAIL run_phase3 got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_11_11_011);
    else n_pass++;
  endtask

  task automatic test_off_restart();
    while (e < 228) clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_00_11_100)
      $display("FAIL off_pre got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_00_11_100);
    else n_pass++;
    while (e < 230) clk_cycle();
    run   = 1'b0;
    pause = 1'b1;
    clk_cycle();
    pause = 1'b0;
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b0)
      $display("FAIL off_outs got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b0);
    else n_pass++;
    n_total++;
    if (tick !== 1'b1) $display("FAIL off_tick e=%0d got %b want 1", e, tick);
    else n_pass++;
    step = 1'b1;
    clk_cycle();
    step = 1'b0;
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b0)
      $display("FAIL off_step got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b0);
    else n_pass++;
    while (e < 235) clk_cycle();
    run = 1'b1;
    clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b11_00_00_000)
      $display("FAIL restart got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b11_00_00_000);
    else n_pass++;
    while (e < 243) clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b11_00_00_000)
      $display("FAIL restart_hold got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b11_00_00_000);
    else n_pass++;
    clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b11_01_00_000)
      $display("FAIL restart_adv got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b11_01_00_000);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [8:1] pat;
    pat = 8'b0100_0100;
    while (e < 332) clk_cycle();
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b00_11_11_011)
      $display("FAIL mid_pre got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b00_11_11_011);
    else n_pass++;
    pause = 1'b1;
    clk_cycle();
    pause = 1'b0;
    while (e < 338) clk_cycle();
    reset_n = 1'b0;
    clk_cycle();
    reset_n = 1'b1;
    n_total++;
    if (tick !== 1'b0) $display("FAIL mid_reset_tick got %b want 0", tick);
    else n_pass++;
    n_total++;
    if ({sw_r, sw_g, sw_b, phase} !== 9'b0)
      $display("FAIL mid_reset_outs got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b0);
    else n_pass++;
    e = 0;
    for (int k = 1; k <= 8; k++) begin
      clk_cycle();
      n_total++;
      if (tick !== pat[k]) $display("FAIL mid_cadence e=%0d got %b want %b", e, tick, pat[k]);
      else n_pass++;
      if (k == 1) begin
        n_total++;
        if ({sw_r, sw_g, sw_b, phase} !== 9'b11_00_00_000)
          $display("FAIL mid_restart got %b want %b", {sw_r, sw_g, sw_b, phase}, 9'b11_00_00_000);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_tick_cadence();
    test_sequence();
    test_pause_step();
    test_off_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
